csk_multiword_add_seq: RTL and testbench

//  Sequences one 11-bit variable-block carry-skip adder core (UBPriVCSkA_10_0, the carry-in variant)
//  to perform a WORDS*11-bit addition over WORDS clock cycles, one 11-bit slice per cycle.

---
 rtl/csk_multiword_add_seq.sv | 185 ++++++++++++++++++
 tb/tb_csk_multiword_add_seq.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/csk_multiword_add_seq.sv
// Multi-word adder: one 11-bit variable-block carry-skip core reused across WORDS cycles,
// with the inter-slice carry registered. Valid/ready handshake on operand and result sides.

// Ripple block with a skip path: when every bit propagates, the block carry-out is taken
// straight from the block carry-in instead of waiting for the ripple chain.
module csk_block #(
  parameter int unsigned W = 2
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         ci,
  output logic [W-1:0] s,
  output logic         co
);
  logic [W-1:0] p;
  logic [W-1:0] g;
  logic         rc;

  assign p = a ^ b;
  assign g = a & b;

  always_comb begin
    logic cy;
    cy = ci;
    s  = '0;
    for (int i = 0; i < int'(W); i++) begin
      s[i] = p[i] ^ cy;
      cy   = g[i] | (p[i] & cy);
    end
    rc = cy;
  end

  assign co = (&p) ? ci : rc;
endmodule

// 11-bit variable-block carry-skip adder with carry-in; blocks of 1,2,3,3,2 bits LSB first.
module UBPriVCSkA_10_0 (
  input  logic [10:0] a,
  input  logic [10:0] b,
  input  logic        cin,
  output logic [11:0] sum
);
  logic c1;
  logic c2;
  logic c3;
  logic c4;
  logic c5;

  csk_block #(.W(1)) u_b0 (.a(a[0]),     .b(b[0]),     .ci(cin), .s(sum[0]),     .co(c1));
  csk_block #(.W(2)) u_b1 (.a(a[2:1]),   .b(b[2:1]),   .ci(c1),  .s(sum[2:1]),   .co(c2));
  csk_block #(.W(3)) u_b2 (.a(a[5:3]),   .b(b[5:3]),   .ci(c2),  .s(sum[5:3]),   .co(c3));
  csk_block #(.W(3)) u_b3 (.a(a[8:6]),   .b(b[8:6]),   .ci(c3),  .s(sum[8:6]),   .co(c4));
  csk_block #(.W(2)) u_b4 (.a(a[10:9]),  .b(b[10:9]),  .ci(c4),  .s(sum[10:9]),  .co(c5));

  assign sum[11] = c5;
endmodule

module csk_multiword_add_seq #(
  parameter int unsigned WORDS = 4
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                IN_VALID,
  output logic                IN_READY,
  input  logic [WORDS*11-1:0] X,
  input  logic [WORDS*11-1:0] Y,
  input  logic                CIN,
  output logic                OUT_VALID,
  input  logic                OUT_READY,
  output logic [WORDS*11-1:0] S,
  output logic                COUT,
  output logic                BUSY
);
  localparam int unsigned SLICE = 11;
  localparam int unsigned N     = WORDS * SLICE;
  localparam int unsigned IW    = $clog2(WORDS + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;
  state_t state_nx;

  logic [N-1:0]     x_r;
  logic [N-1:0]     y_r;
  logic [N-1:0]     s_r;
  logic             carry_r;
  logic             cout_r;
  logic             out_valid_r;
  logic [IW-1:0]    idx;

  logic             accept;
  logic             run;
  logic             last;
  logic             retire;
  logic [SLICE-1:0] core_x;
  logic [SLICE-1:0] core_y;
  logic [SLICE:0]   core_s;

  // State register
  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (IN_VALID)  state_nx = RUN;
      RUN:     if (last)      state_nx = DONE;
      DONE:    if (OUT_READY) state_nx = IDLE;
      default:                state_nx = IDLE;
    endcase
  end

  // Decoded controls; IN_READY depends on state alone
  always_comb begin
    IN_READY = 1'b0;
    BUSY     = 1'b0;
    run      = 1'b0;
    last     = 1'b0;
    retire   = 1'b0;
    case (state)
      IDLE: IN_READY = 1'b1;
      RUN: begin
        BUSY = 1'b1;
        run  = 1'b1;
        last = (idx == IW'(WORDS - 1));
      end
      DONE: begin
        BUSY   = 1'b1;
        retire = OUT_READY;
      end
      default: ;
    endcase
    accept = IN_READY & IN_VALID;
  end

  assign core_x = x_r[idx*SLICE +: SLICE];
  assign core_y = y_r[idx*SLICE +: SLICE];

  UBPriVCSkA_10_0 u_core (
    .a   (core_x),
    .b   (core_y),
    .cin (carry_r),
    .sum (core_s)
  );

  // Operand capture, slice accumulation and result registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      x_r         <= '0;
      y_r         <= '0;
      s_r         <= '0;
      carry_r     <= 1'b0;
      cout_r      <= 1'b0;
      out_valid_r <= 1'b0;
      idx         <= '0;
    end else begin
      out_valid_r <= (state_nx == DONE);
      if (accept) begin
        x_r     <= X;
        y_r     <= Y;
        carry_r <= CIN;
        idx     <= '0;
        s_r     <= '0;
      end
      if (run) begin
        s_r[idx*SLICE +: SLICE] <= core_s[SLICE-1:0];
        carry_r                 <= core_s[SLICE];
        idx                     <= idx + IW'(1);
        if (last) cout_r <= core_s[SLICE];
      end
      if (retire) idx <= '0;
    end
  end

  assign S         = s_r;
  assign COUT      = cout_r;
  assign OUT_VALID = out_valid_r;
endmodule

// File: tb/tb_csk_multiword_add_seq.sv
// Bench for csk_multiword_add_seq: directed and random additions against a plain-arithmetic
// model, for WORDS=4 and WORDS=1 instances.
module tb_csk_multiword_add_seq;
  localparam int unsigned W = 4;
  localparam int unsigned N = 44;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         in_valid, in_ready, cin, out_valid, out_ready, cout, busy;
  logic [N-1:0] x, y, s;

  logic         in_valid1, in_ready1, cin1, out_valid1, out_ready1, cout1, busy1;
  logic [10:0]  x1, y1, s1;

  int errors = 0;
  int checks = 0;

  csk_multiword_add_seq #(.WORDS(W)) dut (
    .CLK(clk), .RST(rst), .IN_VALID(in_valid), .IN_READY(in_ready),
    .X(x), .Y(y), .CIN(cin), .OUT_VALID(out_valid), .OUT_READY(out_ready),
    .S(s), .COUT(cout), .BUSY(busy)
  );

  csk_multiword_add_seq #(.WORDS(1)) dut1 (
    .CLK(clk), .RST(rst), .IN_VALID(in_valid1), .IN_READY(in_ready1),
    .X(x1), .Y(y1), .CIN(cin1), .OUT_VALID(out_valid1), .OUT_READY(out_ready1),
    .S(s1), .COUT(cout1), .BUSY(busy1)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [N:0] ref_sum(input logic [N-1:0] a, input logic [N-1:0] b,
                                         input logic c);
    return {1'b0, a} + {1'b0, b} + {{N{1'b0}}, c};
  endfunction

  function automatic logic [N-1:0] rnd();
    return N'({$urandom(), $urandom()});
  endfunction

  // One full transaction with optional extra backpressure cycles; inputs are scrambled after accept
  task automatic do_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic c,
                       input int stall);
    logic [N:0] e;
    int n;
    int lat;
    e = ref_sum(a, b, c);
    x = a; y = b; cin = c; in_valid = 1'b1; out_ready = 1'b0;
    n = 0;
    while (!in_ready && n < 20) begin step(); n++; end
    chk("op_in_ready", 64'(in_ready), 64'd1);
    step();
    in_valid = 1'b0; x = rnd(); y = rnd(); cin = ~c;
    lat = 0;
    while (!out_valid && lat < 40) begin step(); lat++; end
    chk("op_latency", 64'(lat), 64'(W));
    repeat (stall) step();
    chk("op_sum", 64'(s), 64'(e[N-1:0]));
    chk("op_cout", 64'(cout), 64'(e[N]));
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("op_released", 64'(out_valid), 64'd0);
  endtask

  initial begin
    logic [N:0] e;
    logic [N:0] q[$];
    logic [11:0] e1;
    int t[3];
    int nacc, nres, seen;
    logic acc_now;

    rst = 1'b1;
    in_valid = 1'b0; out_ready = 1'b0; x = '0; y = '0; cin = 1'b0;
    in_valid1 = 1'b0; out_ready1 = 1'b0; x1 = '0; y1 = '0; cin1 = 1'b0;
    step(); step();
    rst = 1'b0;
    step();

    // Reset state
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_s", 64'(s), 64'd0);
    chk("rst_cout", 64'(cout), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);

    // All-ones plus one: carry ripples through every slice
    do_op(44'hFFF_FFFF_FFFF, 44'd1, 1'b0, 0);
    chk("t1_s", 64'(s), 64'd0);
    chk("t1_cout", 64'(cout), 64'd1);

    // Directed sum with handshake observation, then extended backpressure
    x = 44'h12_3456_789A; y = 44'h0F_EDCB_A987; cin = 1'b1;
    in_valid = 1'b1; out_ready = 1'b0;
    chk("t2_in_ready_idle", 64'(in_ready), 64'd1);
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("t2_in_ready_busy", 64'(in_ready), 64'd0);
      chk("t2_busy", 64'(busy), 64'd1);
      if (i < 4) step();
    end
    chk("t2_out_valid", 64'(out_valid), 64'd1);
    chk("t2_s", 64'(s), 64'h22_2222_2222);
    chk("t2_cout", 64'(cout), 64'd0);

    for (int i = 0; i < 5; i++) begin
      in_valid = ~in_valid;
      x = rnd();
      step();
      chk("t3_s_hold", 64'(s), 64'h22_2222_2222);
      chk("t3_cout_hold", 64'(cout), 64'd0);
      chk("t3_out_valid_hold", 64'(out_valid), 64'd1);
      chk("t3_in_ready", 64'(in_ready), 64'd0);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("t3_out_valid_drop", 64'(out_valid), 64'd0);
    step();
    chk("t3_no_new_accept", 64'(busy), 64'd0);

    // Reset in the middle of RUN
    x = rnd(); y = rnd(); cin = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t4_busy", 64'(busy), 64'd0);
    chk("t4_in_ready", 64'(in_ready), 64'd1);
    chk("t4_s", 64'(s), 64'd0);
    chk("t4_cout", 64'(cout), 64'd0);
    chk("t4_out_valid", 64'(out_valid), 64'd0);
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (out_valid) seen = 1;
    end
    chk("t4_no_result", 64'(seen), 64'd0);
    out_ready = 1'b0;

    // Back-to-back operations with both handshakes held high
    x = rnd(); y = rnd(); cin = 1'($urandom());
    in_valid = 1'b1; out_ready = 1'b1;
    nacc = 0; nres = 0;
    for (int cyc = 0; cyc < 60 && nres < 3; cyc++) begin
      acc_now = in_ready && in_valid && (nacc < 3);
      if (acc_now) begin
        q.push_back(ref_sum(x, y, cin));
        t[nacc] = cyc;
        nacc++;
      end
      if (out_valid) begin
        if (q.size() > 0) begin
          e = q.pop_front();
          chk("t5_s", 64'(s), 64'(e[N-1:0]));
          chk("t5_cout", 64'(cout), 64'(e[N]));
          nres++;
        end else begin
          chk("t5_spurious_result", 64'(out_valid), 64'd0);
        end
      end
      step();
      if (acc_now) begin
        x = rnd(); y = rnd(); cin = 1'($urandom());
        if (nacc == 3) in_valid = 1'b0;
      end
    end
    in_valid = 1'b0; out_ready = 1'b0;
    chk("t5_results", 64'(nres), 64'd3);
    chk("t5_spacing_01", 64'(t[1] - t[0]), 64'd6);
    chk("t5_spacing_12", 64'(t[2] - t[1]), 64'd6);

    // Random and corner operations with random backpressure
    do_op(44'hFFF_FFFF_FFFF, 44'd0, 1'b1, 1);
    do_op(44'd0, 44'd0, 1'b0, 0);
    do_op(44'hFFF_FFFF_FFFF, 44'hFFF_FFFF_FFFF, 1'b1, 2);
    for (int i = 0; i < 6; i++)
      do_op(rnd(), rnd(), 1'($urandom()), int'($urandom_range(0, 3)));

    // Single-slice instance
    x1 = 11'h7FF; y1 = 11'h7FF; cin1 = 1'b1; in_valid1 = 1'b1; out_ready1 = 1'b0;
    chk("t6_in_ready", 64'(in_ready1), 64'd1);
    step();
    in_valid1 = 1'b0; x1 = 11'd0; y1 = 11'd0; cin1 = 1'b0;
    chk("t6_running", 64'(out_valid1), 64'd0);
    step();
    chk("t6_out_valid", 64'(out_valid1), 64'd1);
    chk("t6_s", 64'(s1), 64'h7FF);
    chk("t6_cout", 64'(cout1), 64'd1);
    out_ready1 = 1'b1;
    step();
    out_ready1 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      x1 = 11'($urandom()); y1 = 11'($urandom()); cin1 = 1'($urandom());
      e1 = {1'b0, x1} + {1'b0, y1} + {11'd0, cin1};
      in_valid1 = 1'b1;
      step();
      in_valid1 = 1'b0;
      step();
      chk("t6r_out_valid", 64'(out_valid1), 64'd1);
      chk("t6r_s", 64'(s1), 64'(e1[10:0]));
      chk("t6r_cout", 64'(cout1), 64'(e1[11]));
      out_ready1 = 1'b1;
      step();
      out_ready1 = 1'b0;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
